// File: rtl/bus_responder.sv
// Memory-side responder for the CPU data bus: decodes each bus cycle into a
// word RAM or an MMIO page holding a GPIO latch, a cycle counter and a TX byte FIFO.
module bus_responder #(
   parameter int          ADDR_W     = 10,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        rw,
   output logic [31:0] rdata,
   output logic [31:0] gpio_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [3:0] OFF_GPIO   = 4'd0;
   localparam logic [3:0] OFF_CYCLE  = 4'd1;
   localparam logic [3:0] OFF_TXDATA = 4'd2;
   localparam logic [3:0] OFF_STATUS = 4'd3;

   logic [31:0] mem [2**ADDR_W];
   logic [7:0]  fifo_mem [FIFO_DEPTH];

   logic [31:0] cycle_cnt;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          tx_prev;

   logic              is_io;
   logic [3:0]        offset;
   logic [ADDR_W-1:0] ram_idx;
   logic              wr_io;
   logic              wr_ram;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push_cond;
   logic              push_req;
   logic              push_accept;
   logic              push_drop;
   logic              pop;
   logic              ovf_clear;
   logic              cycle_clear;
   logic              gpio_write;
   logic [31:0]       status_word;
   logic [31:0]       io_rdata;
   logic [31:0]       rd_value;
   logic              unused_addr;

   // Only address[31:16] (page match), address[3:0] (IO offset) and the
   // RAM index take part in decode; the remaining bits alias.
   assign unused_addr = ^address[15:4];

   assign is_io   = (address[31:16] == IO_BASE[31:16]);
   assign offset  = address[3:0];
   assign ram_idx = address[ADDR_W-1:0];
   assign wr_io   = is_io & rw;
   assign wr_ram  = ~is_io & rw;

   assign gpio_write  = wr_io & (offset == OFF_GPIO);
   assign cycle_clear = wr_io & (offset == OFF_CYCLE);
   assign ovf_clear   = wr_io & (offset == OFF_STATUS) & wdata[2];

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));

   // Handshake: tx_valid is high while the FIFO holds a byte and tx_data shows
   // the head; a byte transfers on each rising edge where tx_valid & tx_ready.
   assign tx_valid = ~fifo_empty;
   assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
   assign pop      = tx_valid & tx_ready;

   // A TXDATA write held over several cycles must push only once.
   assign push_cond   = wr_io & (offset == OFF_TXDATA);
   assign push_req    = push_cond & ~tx_prev;
   assign push_accept = push_req & (~fifo_full | pop);
   assign push_drop   = push_req & fifo_full & ~pop;

   assign status_word = {16'h0000, 8'(count), 5'b00000, overflow, fifo_full, fifo_empty};

   always_comb begin
      io_rdata = 32'h0000_0000;
      case (offset)
         OFF_GPIO:   io_rdata = gpio_out;
         OFF_CYCLE:  io_rdata = cycle_cnt;
         OFF_STATUS: io_rdata = status_word;
         default:    io_rdata = 32'h0000_0000;
      endcase
   end

   assign rd_value = is_io ? io_rdata : mem[ram_idx];

   // RAM has no reset so its contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (wr_ram) begin
         mem[ram_idx] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (push_accept) begin
         fifo_mem[wr_ptr] <= wdata[7:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata     <= 32'h0000_0000;
         gpio_out  <= 32'h0000_0000;
         cycle_cnt <= 32'h0000_0000;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         tx_prev   <= 1'b0;
      end else begin
         rdata   <= rd_value;
         tx_prev <= push_cond;

         if (gpio_write) begin
            gpio_out <= wdata;
         end

         if (cycle_clear) begin
            cycle_cnt <= 32'h0000_0000;
         end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end

         if (push_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({push_accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // A drop in the same edge as a clear leaves the flag set.
         if (push_drop) begin
            overflow <= 1'b1;
         end else if (ovf_clear) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: vector table for the decode/read path,
// then directed sequences for the TX FIFO, CYCLE clear and mid-operation reset.
module tb_bus_responder;

   logic        clock;
   logic        reset;
   logic [31:0] address;
   logic [31:0] wdata;
   logic        rw;
   logic [31:0] rdata;
   logic [31:0] gpio_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int n_checks;
   int n_fail;

   logic [31:0] exp_q[$];
   logic [7:0]  tx_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
      logic        wr;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];

   localparam logic [31:0] A_GPIO   = 32'hFFFF_0000;
   localparam logic [31:0] A_CYCLE  = 32'hFFFF_0001;
   localparam logic [31:0] A_TXDATA = 32'hFFFF_0002;
   localparam logic [31:0] A_STATUS = 32'hFFFF_0003;

   bus_responder #(
      .ADDR_W     (10),
      .FIFO_DEPTH (4),
      .IO_BASE    (32'hFFFF_0000)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .address  (address),
      .wdata    (wdata),
      .rw       (rw),
      .rdata    (rdata),
      .gpio_out (gpio_out),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: drive inputs just after an edge, check any TX handshake
   // that the coming edge completes, then compare rdata after the edge.
   task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic rdy, input logic chk, input logic [31:0] exp);
      logic [31:0] e;
      address  = a;
      wdata    = d;
      rw       = w;
      tx_ready = rdy;
      if (chk) exp_q.push_back(exp);
      if (rdy && tx_q.size() > 0) begin
         check("tx_valid_at_pop", {31'd0, tx_valid}, 32'd1);
         check("tx_data_at_pop", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
      end
      @(posedge clock);
      #1;
      if (chk) begin
         e = exp_q.pop_front();
         check("rdata", rdata, e);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      address  = 32'h0;
      wdata    = 32'h0;
      rw       = 1'b0;
      tx_ready = 1'b0;

      vecs[0]  = '{A_STATUS,      32'h0,        1'b0, 1'b1, 32'h0000_0001};
      vecs[1]  = '{32'h0000_0005, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      vecs[2]  = '{32'h0000_0405, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
      vecs[3]  = '{A_GPIO,        32'h1234_5678, 1'b1, 1'b1, 32'h0};
      vecs[4]  = '{A_GPIO,        32'h0,        1'b0, 1'b1, 32'h1234_5678};
      vecs[5]  = '{A_CYCLE,       32'h0000_ABCD, 1'b1, 1'b0, 32'h0};
      vecs[6]  = '{32'hFFFF_0005, 32'h0,        1'b0, 1'b1, 32'h0};
      vecs[7]  = '{A_CYCLE,       32'h0,        1'b0, 1'b1, 32'h1};
      vecs[8]  = '{A_CYCLE,       32'h0,        1'b0, 1'b1, 32'h2};
      vecs[9]  = '{A_TXDATA,      32'h0,        1'b0, 1'b1, 32'h0};
      vecs[10] = '{32'hFFFF_0004, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
      vecs[11] = '{32'hFFFF_0004, 32'h0,        1'b0, 1'b1, 32'h0};
      vecs[12] = '{32'h0000_0010, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0};
      vecs[13] = '{32'h0000_0010, 32'h1111_1111, 1'b1, 1'b1, 32'h0BAD_F00D};
      vecs[14] = '{32'h0000_0010, 32'h0,        1'b0, 1'b1, 32'h1111_1111};
      vecs[15] = '{32'h1234_0010, 32'h0,        1'b0, 1'b1, 32'h1111_1111};

      repeat (3) @(posedge clock);
      #1;
      check("reset_rdata", rdata, 32'h0);
      check("reset_gpio", gpio_out, 32'h0);
      check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("reset_tx_data", {24'd0, tx_data}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         cycle(vecs[i].addr, vecs[i].wd, vecs[i].wr, 1'b0, vecs[i].chk, vecs[i].exp);
      end
      check("gpio_latch", gpio_out, 32'h1234_5678);

      // five single-cycle pushes into a 4-deep FIFO; status read between each
      for (int k = 0; k < 5; k++) begin
         logic [31:0] st;
         int c;
         c  = (k + 1 > 4) ? 4 : k + 1;
         st = (32'(c) << 8) | ((k + 1 >= 4) ? 32'h2 : 32'h0) | ((k + 1 > 4) ? 32'h4 : 32'h0);
         cycle(A_TXDATA, 32'h0000_0041 + 32'(k), 1'b1, 1'b0, 1'b1, 32'h0);
         cycle(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, st);
      end
      check("full_tx_valid", {31'd0, tx_valid}, 32'd1);
      check("full_head", {24'd0, tx_data}, 32'h41);

      // clear overflow, confirm it stays clear
      cycle(A_STATUS, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'h0000_0406);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0402);

      // push while full with a pop in the same edge
      tx_q = {8'h41, 8'h42, 8'h43, 8'h44};
      cycle(A_TXDATA, 32'h0000_0099, 1'b1, 1'b1, 1'b1, 32'h0);
      tx_q.push_back(8'h99);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0402);

      // drain, then a pop attempt while empty
      cycle(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0402);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0001);
      check("drained_queue", 32'(tx_q.size()), 32'd0);
      check("drained_tx_valid", {31'd0, tx_valid}, 32'd0);

      // TXDATA write held for three cycles pushes once
      repeat (3) cycle(A_TXDATA, 32'h0000_0055, 1'b1, 1'b0, 1'b1, 32'h0);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
      tx_q.push_back(8'h55);

      // CYCLE cleared by write reads back 1 two cycles later
      cycle(A_CYCLE, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      cycle(A_GPIO, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
      cycle(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1);

      // fill to 4, pop one, then reset with three bytes queued
      for (int k = 0; k < 3; k++) begin
         cycle(A_TXDATA, 32'h0000_0066 + 32'(k * 17), 1'b1, 1'b0, 1'b1, 32'h0);
         cycle(A_GPIO, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
         tx_q.push_back(8'h66 + 8'(k * 17));
      end
      cycle(32'h0000_0405, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);

      tx_ready = 1'b1;
      reset    = 1'b1;
      #1;
      check("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("midreset_tx_data", {24'd0, tx_data}, 32'd0);
      check("midreset_rdata", rdata, 32'h0);
      check("midreset_gpio", gpio_out, 32'h0);
      tx_q.delete();
      exp_q.delete();
      @(posedge clock);
      #1;
      reset    = 1'b0;
      tx_ready = 1'b0;

      cycle(32'h0000_0005, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      cycle(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
      cycle(A_GPIO, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
      cycle(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
